// File: rtl/score_disp_pkg.sv
// score_disp_pkg: shared definitions for the score display controller.
//   - Seven-segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
//   - FSM state encoding; the encoding is also the win_state output value.
//   - seg_digit(): decimal digit (0..9) to segment pattern, BLANK otherwise.
package score_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WIN_L = 2'b01,
    WIN_R = 2'b10
  } state_e;

  function automatic logic [6:0] seg_digit(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_digit_enc.sv
// seg_digit_enc: converts one player's score (0..99) to two seven-segment patterns.
// Ports:
//   value    - binary score, only 0..99 is meaningful
//   dash     - score is out of display range; both digits show DASH
//   tens_seg - tens digit pattern, BLANK when the score is below 10
//   ones_seg - ones digit pattern
module seg_digit_enc
  import score_disp_pkg::*;
(
  input  logic [6:0] value,
  input  logic       dash,
  output logic [6:0] tens_seg,
  output logic [6:0] ones_seg
);

  logic [3:0] tens_num;
  logic [3:0] ones_num;

  always_comb begin
    // Division by a constant on a 7-bit value stays a small combinational block.
    tens_num = 4'(value / 7'd10);
    ones_num = 4'(value % 7'd10);
    if (dash) begin
      tens_seg = SEG_DASH;
      ones_seg = SEG_DASH;
    end else begin
      tens_seg = (tens_num == 4'd0) ? SEG_BLANK : seg_digit(tens_num);
      ones_seg = seg_digit(ones_num);
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: builds the 8-digit score / winner banner for SevenSegmentLED.
// Ports:
//   clock        - sole clock, rising edge
//   reset        - asynchronous, active-low
//   leftpscore   - player 1 score (unsigned)
//   rightpscore  - player 2 score (unsigned)
//   gamestate    - 1 = game running, 0 = game over / checking for a winner
//   AN_In        - digit enables, 1 = lit, bit 7 is the leftmost digit
//   C_In         - segment patterns, 7 bits per digit, digit 7 in [55:49]
//   win_state    - 00 running, 01 left won, 10 right won
// All outputs are registered from the current state and the inputs at the same edge,
// so a state change reaches the outputs one edge after the transition edge.
module score_display_ctrl
  import score_disp_pkg::*;
#(
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 3,
  parameter int unsigned BLINK_CYCLES = 50_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SCORE_W-1:0] leftpscore,
  input  logic [SCORE_W-1:0] rightpscore,
  input  logic               gamestate,
  output logic [7:0]         AN_In,
  output logic [55:0]        C_In,
  output logic [1:0]         win_state
);

  localparam int unsigned CNT_W = $clog2(BLINK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;  // 1 = ON (digits lit)

  logic [7:0]  an_q, an_d;
  logic [55:0] c_q, c_d;
  logic [1:0]  ws_q, ws_d;

  // Zero-extend so range and win comparisons work for any SCORE_W.
  logic [31:0] left_ext, right_ext;
  logic        left_dash, right_dash;
  logic        left_win, right_win;
  logic [6:0]  left_tens, left_ones, right_tens, right_ones;

  assign left_ext   = 32'(leftpscore);
  assign right_ext  = 32'(rightpscore);
  assign left_dash  = left_ext > 32'd99;
  assign right_dash = right_ext > 32'd99;
  assign left_win   = left_ext >= WIN_SCORE;
  assign right_win  = right_ext >= WIN_SCORE;

  seg_digit_enc u_left_enc (
    .value    (left_ext[6:0]),
    .dash     (left_dash),
    .tens_seg (left_tens),
    .ones_seg (left_ones)
  );

  seg_digit_enc u_right_enc (
    .value    (right_ext[6:0]),
    .dash     (right_dash),
    .tens_seg (right_tens),
    .ones_seg (right_ones)
  );

  // Next state, blink counter and phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      RUN: begin
        // Counter and phase are held cleared so a win always starts ON from 0.
        cnt_d   = '0;
        phase_d = 1'b1;
        if (!gamestate) begin
          if (left_win) begin
            state_d = WIN_L;
          end else if (right_win) begin
            state_d = WIN_R;
          end
        end
      end
      WIN_L, WIN_R: begin
        if (gamestate) begin
          state_d = RUN;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        phase_d = 1'b1;
      end
    endcase
  end

  // Output image for the current state; registered below.
  always_comb begin
    an_d = 8'h00;
    c_d  = '0;
    ws_d = state_q;
    case (state_q)
      RUN: begin
        an_d = 8'hFF;
        c_d  = {SEG_P, SEG_1, left_tens, left_ones, SEG_P, SEG_2, right_tens, right_ones};
      end
      WIN_L: begin
        an_d = phase_q ? 8'hFF : 8'h00;
        c_d  = {SEG_P, SEG_1, SEG_BLANK, SEG_BLANK, SEG_P, SEG_1, SEG_BLANK, SEG_BLANK};
      end
      WIN_R: begin
        an_d = phase_q ? 8'hFF : 8'h00;
        c_d  = {SEG_P, SEG_2, SEG_BLANK, SEG_BLANK, SEG_P, SEG_2, SEG_BLANK, SEG_BLANK};
      end
      default: begin
        an_d = 8'h00;
        c_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      an_q    <= 8'h00;
      c_q     <= '0;
      ws_q    <= RUN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      c_q     <= c_d;
      ws_q    <= ws_d;
    end
  end

  assign AN_In     = an_q;
  assign C_In      = c_q;
  assign win_state = ws_q;

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameter SCORE_W, default 4: width of each player score input.
REQ-002 Parameter WIN_SCORE, default 3: score at which a player wins; legal range 1..99.
REQ-003 Parameter BLINK_CYCLES, default 50_000_000: clock cycles per blink half-period in a win state; must be at least 2.
REQ-004 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port leftpscore, input, SCORE_W: player 1 score, unsigned.
REQ-007 Port rightpscore, input, SCORE_W: player 2 score, unsigned.
REQ-008 Port gamestate, input, 1: 0 means the game is over or checking; 1 means a new game is running.
REQ-009 Port AN_In, output, 8: digit enables, 1 = lit; bit 7 is the leftmost digit.
REQ-010 Port C_In, output, 56: segment patterns, 7 bits per digit; digit 7 is in [55:49] and digit 0 is in [6:0].
REQ-011 Port win_state, output, 2: 00 = running, 01 = left won, 10 = right won.

Function
REQ-012 Segment encoding is {g,f,e,d,c,b,a}, 1 = lit:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- P=1110011, DASH=1000000, BLANK=0000000
REQ-013 Scores are converted to two decimal digits; a score above 99 is shown as DASH,DASH.
REQ-014 The tens digit is BLANK when the score is below 10.
REQ-015 In RUN, C_In = {P,1,tens_L,ones_L,P,2,tens_R,ones_R} and AN_In = 8'hFF.
REQ-016 The FSM has three states: RUN, WIN_L and WIN_R.
REQ-017 In RUN with gamestate=0, the next state is WIN_L if leftpscore >= WIN_SCORE, else WIN_R if rightpscore >= WIN_SCORE; if both reach WIN_SCORE in the same cycle, WIN_L takes priority.
REQ-018 In RUN with gamestate=1, the FSM stays in RUN regardless of the scores.
REQ-019 In WIN_L, C_In = {P,1,BLANK,BLANK,P,1,BLANK,BLANK}; in WIN_R, C_In = {P,2,BLANK,BLANK,P,2,BLANK,BLANK}.
REQ-020 In WIN_L and WIN_R, score inputs are ignored.
REQ-021 In a win state, a blink counter counts 0..BLINK_CYCLES-1 and wraps to 0.
- At each wrap, the blink phase toggles.
- AN_In = 8'hFF in the ON phase and 8'h00 in the OFF phase.
REQ-022 On entry to a win state, the blink counter clears to 0 and the phase is ON.
REQ-023 In a win state with gamestate=1, the next state is RUN; the counter clears and the phase is set to ON.
REQ-024 All outputs are registered.
- C_In and AN_In reflect inputs sampled one cycle earlier.
- A state change is visible on the outputs one cycle after the transition edge.
REQ-025 win_state equals the registered FSM state encoding.

Reset
REQ-026 While reset=0, asynchronously:
- state = RUN, counter = 0, phase = ON
- AN_In = 8'h00, C_In = 56'h0, win_state = 00
REQ-027 Reset asserted mid-blink aborts the win state immediately.
REQ-028 After reset deasserts, the first clock edge loads RUN outputs from the current inputs.

Structure
REQ-029 Package score_disp_pkg holds:
- the segment constants of REQ-012
- the state enum RUN=00, WIN_L=01, WIN_R=10
REQ-030 One sub-module, seg_digit_enc, maps a 0..99 value to two 7-bit patterns (tens with leading-zero blank, ones) and is instantiated once per player.
REQ-031 The block feeds SevenSegmentLED unchanged; it does not multiplex digits itself.

Verification
REQ-032 Reset with L=2, R=1, gamestate=1: outputs are 0 during reset; one edge after release, C_In = {P,1,BLANK,2,P,2,BLANK,1} and AN_In = FF.
REQ-033 SCORE_W=7, L=47, R=100: digits show P,1,4,7,P,2,DASH,DASH.
REQ-034 WIN_SCORE=3, gamestate=0, L=3 and R=3 in the same cycle: win_state = 01, and C_In shows the P1 banner.
REQ-035 BLINK_CYCLES=4, right wins:
- AN_In = FF for 4 cycles, then 00 for 4 cycles, repeating.
- Raising gamestate returns the block to RUN on the next cycle with AN_In = FF.
REQ-036 In WIN_R, assert reset on an OFF-phase cycle: immediately win_state = 00, AN_In = 00, C_In = 0.
REQ-037 In RUN with gamestate=1 and L=5 (≥ WIN_SCORE): no transition; the display shows the score.
